hls_core_staller_mc: RTL and testbench

Parametrised multi-channel stall controller for NVDLA HLS datapath cores (fp32 add/mul and successors). Combines the write-enable completion flags of N_IN input and N_OUT output channels into the core enable `core_wen` and its registered complement `core_wten`. Adds a software freeze, per-episode stall-cause capture, a saturating consecutive-stall counter and a sticky stall-timeout watchdog. Sits between the channel rsci interface blocks and the core datapath registers.

---
 rtl/hls_staller_pkg.sv | 21 ++
 rtl/hls_staller_sat_cnt.sv | 34 +++
 rtl/hls_core_staller_mc.sv | 175 +++++++++++++++++
 tb/tb_hls_core_staller_mc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hls_staller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hls_staller_pkg
// Description : Shared types and constants for the HLS core stall controller.
//               State encoding, state width and perf counter widths.
// Revision    : 1.0  initial release
// ============================================================================
package hls_staller_pkg;

    localparam int c_STATE_W        = 2;
    localparam int c_PERF_TOTAL_W   = 32;
    localparam int c_PERF_EPISODE_W = 16;

    typedef enum logic [c_STATE_W-1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_TIMEOUT = 2'd2
    } stall_state_e;

endpackage : hls_staller_pkg
`default_nettype wire

// File: rtl/hls_staller_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hls_staller_sat_cnt
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment; the count holds at all-ones.
// Revision    : 1.0  initial release
// ============================================================================
module hls_staller_sat_cnt #(
    parameter int W = 8
) (
    input  logic         nvdla_core_clk,
    input  logic         nvdla_core_rstn,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up on increment, stop at all-ones, clear to zero on request.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule : hls_staller_sat_cnt
`default_nettype wire

// File: rtl/hls_core_staller_mc.sv
`default_nettype none
// ============================================================================
// Module      : hls_core_staller_mc
// Description : Multi-channel stall controller for HLS datapath cores.
//               Combines channel completion flags and a software freeze into
//               the core enable, captures the stall cause per episode, counts
//               consecutive stall cycles and raises a sticky watchdog flag.
//               Optional perf counters are built when HLS_STALLER_PERF_EN is
//               defined; otherwise those ports read constant zero.
// Revision    : 1.0  initial release
// ============================================================================
module hls_core_staller_mc
    import hls_staller_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1,
    parameter int CNT_W = 8
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    input  logic [N_IN-1:0]        chn_in_wen_comp,
    input  logic [N_OUT-1:0]       chn_out_wen_comp,
    input  logic                   core_freeze,
    input  logic [CNT_W-1:0]       timeout_thr,
    input  logic                   timeout_clr,
    output logic                   core_wen,
    output logic                   core_wten,
    output logic [N_IN+N_OUT-1:0]  stall_cause,
    output logic [CNT_W-1:0]       stall_run_cnt,
    output logic                   stall_timeout,
    output logic [c_STATE_W-1:0]   stall_state,
    output logic [31:0]            stall_total_cnt,
    output logic [15:0]            stall_episode_cnt
);

    stall_state_e            r_state;
    stall_state_e            w_state_nxt;
    logic                    w_core_wen;
    logic                    w_stall;
    logic                    w_thr_hit;
    logic                    w_episode_start;
    logic                    w_to_timeout;
    logic [CNT_W:0]          w_cnt_inc;
    logic                    r_core_wten;
    logic [N_IN+N_OUT-1:0]   r_stall_cause;
    logic                    r_stall_timeout;
    logic [CNT_W-1:0]        w_run_cnt;

    assign w_core_wen = (&chn_in_wen_comp) & (&chn_out_wen_comp) & ~core_freeze;
    assign w_stall    = ~w_core_wen;

    // Compare one bit wider so a saturated count still reaches any threshold.
    assign w_cnt_inc  = {1'b0, w_run_cnt} + 1'b1;
    assign w_thr_hit  = (timeout_thr != '0) && (w_cnt_inc >= {1'b0, timeout_thr});

    // State register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave RUN on any stall, return to RUN on any enable cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_stall) w_state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (w_core_wen)     w_state_nxt = ST_RUN;
                else if (w_thr_hit) w_state_nxt = ST_TIMEOUT;
            end
            ST_TIMEOUT: begin
                if (w_core_wen) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: episode start strobe and watchdog firing strobe.
    always_comb begin
        w_episode_start = 1'b0;
        w_to_timeout    = 1'b0;
        case (r_state)
            ST_RUN:   w_episode_start = w_stall;
            ST_STALL: w_to_timeout    = w_stall & w_thr_hit;
            default: begin
                w_episode_start = 1'b0;
                w_to_timeout    = 1'b0;
            end
        endcase
    end

    // Registered complement of the enable for downstream write-timing.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_core_wten <= 1'b0;
        end else begin
            r_core_wten <= ~w_core_wen;
        end
    end

    // Latch the not-ready mask at the first stall cycle of each episode.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_cause <= '0;
        end else if (w_episode_start) begin
            r_stall_cause <= {~chn_out_wen_comp, ~chn_in_wen_comp};
        end
    end

    // Sticky watchdog flag; a new firing wins over a simultaneous clear.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_timeout <= 1'b0;
        end else if (w_to_timeout) begin
            r_stall_timeout <= 1'b1;
        end else if (timeout_clr) begin
            r_stall_timeout <= 1'b0;
        end
    end

    hls_staller_sat_cnt #(
        .W (CNT_W)
    ) u_run_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_inc           (w_stall),
        .i_clr           (w_core_wen),
        .o_cnt           (w_run_cnt)
    );

`ifdef HLS_STALLER_PERF_EN
    logic [c_PERF_TOTAL_W-1:0]   w_total_cnt;
    logic [c_PERF_EPISODE_W-1:0] w_episode_cnt;

    hls_staller_sat_cnt #(
        .W (c_PERF_TOTAL_W)
    ) u_total_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_inc           (w_stall),
        .i_clr           (1'b0),
        .o_cnt           (w_total_cnt)
    );

    hls_staller_sat_cnt #(
        .W (c_PERF_EPISODE_W)
    ) u_episode_cnt (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .i_inc           (w_episode_start),
        .i_clr           (1'b0),
        .o_cnt           (w_episode_cnt)
    );

    assign stall_total_cnt   = w_total_cnt;
    assign stall_episode_cnt = w_episode_cnt;
`else
    assign stall_total_cnt   = '0;
    assign stall_episode_cnt = '0;
`endif

    assign core_wen      = w_core_wen;
    assign core_wten     = r_core_wten;
    assign stall_cause   = r_stall_cause;
    assign stall_run_cnt = w_run_cnt;
    assign stall_timeout = r_stall_timeout;
    assign stall_state   = r_state;

endmodule : hls_core_staller_mc
`default_nettype wire

// File: tb/tb_hls_core_staller_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_hls_core_staller_mc
// Description : Self-checking bench for hls_core_staller_mc (N_IN=2, N_OUT=1,
//               CNT_W=3). Directed scenarios with literal expectations, then
//               randomized traffic checked against an episode-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hls_core_staller_mc;

    localparam int N_IN  = 2;
    localparam int N_OUT = 1;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rstn;
    logic [N_IN-1:0]   chn_in;
    logic [N_OUT-1:0]  chn_out;
    logic              freeze;
    logic [CNT_W-1:0]  thr;
    logic              clr;
    logic              wen;
    logic              wten;
    logic [2:0]        cause;
    logic [CNT_W-1:0]  run_cnt;
    logic              tmo;
    logic [1:0]        state;
    logic [31:0]       total_cnt;
    logic [15:0]       episode_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Episode-level reference state.
    int       m_run_len;
    bit       m_in_ep;
    bit       m_timed;
    bit       m_flag;
    bit       m_wten;
    bit [2:0] m_cause;
    longint   m_total;
    longint   m_episodes;

    hls_core_staller_mc #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .chn_in_wen_comp   (chn_in),
        .chn_out_wen_comp  (chn_out),
        .core_freeze       (freeze),
        .timeout_thr       (thr),
        .timeout_clr       (clr),
        .core_wen          (wen),
        .core_wten         (wten),
        .stall_cause       (cause),
        .stall_run_cnt     (run_cnt),
        .stall_timeout     (tmo),
        .stall_state       (state),
        .stall_total_cnt   (total_cnt),
        .stall_episode_cnt (episode_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_wen();
        return (&chn_in) & (&chn_out) & ~freeze;
    endfunction

    task automatic model_reset();
        m_run_len  = 0;
        m_in_ep    = 0;
        m_timed    = 0;
        m_flag     = 0;
        m_wten     = 0;
        m_cause    = '0;
        m_total    = 0;
        m_episodes = 0;
    endtask

    // One clock edge of the rules: episodes, run length, watchdog, perf.
    task automatic model_step();
        bit w;
        bit set;
        w   = exp_wen();
        set = 0;
        if (!w) begin
            if (!m_in_ep) begin
                m_cause = {~chn_out, ~chn_in};
                m_episodes++;
                m_in_ep = 1;
                m_timed = 0;
            end else if (!m_timed && thr != 0 && (m_run_len + 1) >= int'(thr)) begin
                m_timed = 1;
                set     = 1;
            end
            m_run_len++;
            m_total++;
        end else begin
            m_in_ep   = 0;
            m_timed   = 0;
            m_run_len = 0;
        end
        if (set)      m_flag = 1;
        else if (clr) m_flag = 0;
        m_wten = ~w;
    endtask

    task automatic check_all();
        longint e_total;
        longint e_epi;
        chk("core_wen",    wen, exp_wen());
        chk("core_wten",   wten, m_wten);
        chk("stall_state", state, !m_in_ep ? 0 : (m_timed ? 2 : 1));
        chk("stall_cause", cause, m_cause);
        chk("run_cnt",     run_cnt, (m_run_len > CNT_MAX) ? CNT_MAX : m_run_len);
        chk("timeout",     tmo, m_flag);
`ifdef HLS_STALLER_PERF_EN
        e_total = (m_total > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_total;
        e_epi   = (m_episodes > 65535) ? 65535 : m_episodes;
`else
        e_total = 0;
        e_epi   = 0;
`endif
        chk("total_cnt",   total_cnt, e_total);
        chk("episode_cnt", episode_cnt, e_epi);
    endtask

    // Called at a negedge: drive, check the enable, clock, check registers.
    task automatic cycle(input logic [1:0] i_in, input logic i_out, input logic i_frz, input logic i_clr);
        chn_in  = i_in;
        chn_out = i_out;
        freeze  = i_frz;
        clr     = i_clr;
        #1;
        chk("core_wen_comb", wen, exp_wen());
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse between edges.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        chk("rst_wten",    wten, 0);
        chk("rst_cause",   cause, 0);
        chk("rst_cnt",     run_cnt, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_state",   state, 0);
        chk("rst_total",   total_cnt, 0);
        chk("rst_episode", episode_cnt, 0);
        chk("rst_wen",     wen, exp_wen());
        #2;
        rstn = 1'b1;
    endtask

    initial begin
        longint total_before;
        rstn    = 1'b0;
        chn_in  = 2'b11;
        chn_out = 1'b1;
        freeze  = 1'b0;
        thr     = '0;
        clr     = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // All ready: enable immediately, wten low, RUN.
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        chk("lit_wten_ready", wten, 0);
        chk("lit_state_run",  state, 0);

        // Output channel not ready for three cycles.
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt1", run_cnt, 1);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt2", run_cnt, 2);
        cycle(2'b11, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt3",   run_cnt, 3);
        chk("lit_cause4", cause, 3'b100);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt0", run_cnt, 0);
`ifdef HLS_STALLER_PERF_EN
        chk("lit_episodes1", episode_cnt, 1);
`endif

        // Watchdog at threshold 4 with input channel 1 stalled.
        thr = 3'd4;
        for (int k = 1; k <= 6; k++) begin
            cycle(2'b01, 1'b1, 1'b0, 1'b0);
            if (k == 3) chk("lit_tmo_before", tmo, 0);
            if (k == 4) begin
                chk("lit_tmo_set",    tmo, 1);
                chk("lit_state_tmo",  state, 2);
                chk("lit_cnt_at_thr", run_cnt, 4);
                chk("lit_cause2",     cause, 3'b010);
            end
        end
        cycle(2'b11, 1'b1, 1'b0, 1'b0);
        chk("lit_state_back", state, 0);
        chk("lit_tmo_sticky", tmo, 1);
        cycle(2'b11, 1'b1, 1'b0, 1'b1);
        chk("lit_tmo_cleared", tmo, 0);
        for (int k = 1; k <= 3; k++) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 1'b1);
        chk("lit_set_wins", tmo, 1);
        cycle(2'b11, 1'b1, 1'b0, 1'b1);
        chk("lit_tmo_cleared2", tmo, 0);

        // Saturation with the watchdog disabled.
        thr = '0;
        total_before = m_total;
        for (int k = 0; k < 10; k++) cycle(2'b11, 1'b0, 1'b0, 1'b0);
        chk("lit_cnt_sat",  run_cnt, 7);
        chk("lit_no_tmo",   tmo, 0);
`ifdef HLS_STALLER_PERF_EN
        chk("lit_total_delta", total_cnt, total_before + 10);
`endif
        cycle(2'b11, 1'b1, 1'b0, 1'b0);

        // Software freeze with all channels ready.
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        chk("lit_frz_wen",   wen, 0);
        cycle(2'b11, 1'b1, 1'b1, 1'b0);
        chk("lit_frz_cause", cause, 0);
        chk("lit_frz_cnt",   run_cnt, 2);
        cycle(2'b11, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a stall episode.
        for (int k = 0; k < 5; k++) cycle(2'b10, 1'b1, 1'b0, 1'b0);
        chk("lit_cnt5", run_cnt, 5);
        do_reset();
        cycle(2'b10, 1'b1, 1'b0, 1'b0);
        chk("lit_post_rst_cnt",   run_cnt, 1);
        chk("lit_post_rst_state", state, 1);
        chk("lit_post_rst_cause", cause, 3'b001);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] ri;
            logic       ro;
            logic       rf;
            logic       rc;
            if ($urandom_range(0, 199) == 0) do_reset();
            if ($urandom_range(0, 29) == 0) begin
                thr = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(2, 7));
            end
            ri[0] = ($urandom_range(0, 9) != 0);
            ri[1] = ($urandom_range(0, 9) != 0);
            ro    = ($urandom_range(0, 9) != 0);
            rf    = ($urandom_range(0, 24) == 0);
            rc    = ($urandom_range(0, 19) == 0);
            cycle(ri, ro, rf, rc);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_hls_core_staller_mc
`default_nettype wire
